// File: rtl/reorder_buffer.sv
// Dual-dispatch, dual-retire reorder buffer with three completion ports.
// Retire is combinational from registered state; all updates land on the rising edge.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 7,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid_1,
    input  logic              disp_valid_2,
    input  logic [PREG_W-1:0] disp_destreg_1,
    input  logic [PREG_W-1:0] disp_destreg_2,
    input  logic [PREG_W-1:0] disp_olddest_1,
    input  logic [PREG_W-1:0] disp_olddest_2,
    input  logic [31:0]       disp_pc_1,
    input  logic [31:0]       disp_pc_2,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag_1,
    output logic [TAG_W-1:0]  disp_tag_2,
    input  logic              cmp_valid_1,
    input  logic              cmp_valid_2,
    input  logic              cmp_valid_3,
    input  logic [TAG_W-1:0]  cmp_tag_1,
    input  logic [TAG_W-1:0]  cmp_tag_2,
    input  logic [TAG_W-1:0]  cmp_tag_3,
    output logic              ret_valid_1,
    output logic              ret_valid_2,
    output logic              ret_free_1,
    output logic              ret_free_2,
    output logic [PREG_W-1:0] ret_olddest_1,
    output logic [PREG_W-1:0] ret_olddest_2,
    output logic [PREG_W-1:0] ret_destreg_1,
    output logic [PREG_W-1:0] ret_destreg_2,
    output logic [31:0]       ret_pc_1,
    output logic [31:0]       ret_pc_2,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  complete_q, complete_d;
    logic [PREG_W-1:0] dest_q [DEPTH];
    logic [PREG_W-1:0] old_q  [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [TAG_W-1:0]  head_p1, tail_p1;
    logic              acc_1, acc_2;
    logic [1:0]        n_acc, n_ret;
    logic [2:0]        cmp_v;
    logic [TAG_W-1:0]  cmp_t [3];

    assign head_p1 = head_q + TAG_W'(1);
    assign tail_p1 = tail_q + TAG_W'(1);

    assign cmp_v    = {cmp_valid_3, cmp_valid_2, cmp_valid_1};
    assign cmp_t[0] = cmp_tag_1;
    assign cmp_t[1] = cmp_tag_2;
    assign cmp_t[2] = cmp_tag_3;

    // Readiness looks only at the registered count, so a same-cycle retire never opens the gate.
    assign disp_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign acc_1      = disp_ready & disp_valid_1;
    assign acc_2      = acc_1 & disp_valid_2;
    assign disp_tag_1 = tail_q;
    assign disp_tag_2 = tail_p1;

    assign ret_valid_1 = valid_q[head_q] & complete_q[head_q];
    assign ret_valid_2 = ret_valid_1 & valid_q[head_p1] & complete_q[head_p1];

    assign ret_destreg_1 = ret_valid_1 ? dest_q[head_q]  : '0;
    assign ret_destreg_2 = ret_valid_2 ? dest_q[head_p1] : '0;
    assign ret_olddest_1 = ret_valid_1 ? old_q[head_q]   : '0;
    assign ret_olddest_2 = ret_valid_2 ? old_q[head_p1]  : '0;
    assign ret_pc_1      = ret_valid_1 ? pc_q[head_q]    : '0;
    assign ret_pc_2      = ret_valid_2 ? pc_q[head_p1]   : '0;
    assign ret_free_1    = ret_valid_1 & (old_q[head_q]  != '0);
    assign ret_free_2    = ret_valid_2 & (old_q[head_p1] != '0);

    assign n_acc = {1'b0, acc_1} + {1'b0, acc_2};
    assign n_ret = {1'b0, ret_valid_1} + {1'b0, ret_valid_2};

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        for (int k = 0; k < 3; k++) begin
            if (cmp_v[k] && valid_q[cmp_t[k]]) begin
                complete_d[cmp_t[k]] = 1'b1;
            end
        end
        if (ret_valid_1) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
        end
        if (ret_valid_2) begin
            valid_d[head_p1]    = 1'b0;
            complete_d[head_p1] = 1'b0;
        end
        // Dispatch targets free slots only, so it never collides with a retiring entry.
        if (acc_1) begin
            valid_d[tail_q]    = 1'b1;
            complete_d[tail_q] = 1'b0;
        end
        if (acc_2) begin
            valid_d[tail_p1]    = 1'b1;
            complete_d[tail_p1] = 1'b0;
        end
        head_d  = head_q + TAG_W'(n_ret);
        tail_d  = tail_q + TAG_W'(n_acc);
        count_d = count_q + CNT_W'(n_acc) - CNT_W'(n_ret);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                old_q[i]  <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (acc_1) begin
                dest_q[tail_q] <= disp_destreg_1;
                old_q[tail_q]  <= disp_olddest_1;
                pc_q[tail_q]   <= disp_pc_1;
            end
            if (acc_2) begin
                dest_q[tail_p1] <= disp_destreg_2;
                old_q[tail_p1]  <= disp_olddest_2;
                pc_q[tail_p1]   <= disp_pc_2;
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: DEPTH, 16, number of ROB entries; tag width is log2(DEPTH) = 4.
REQ-002 Parameter: PREG_W, 7, physical register index width (128 pregs).
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: disp_valid_1 / disp_valid_2  in  1  dispatch request, slot 1 older than slot 2.
REQ-006 Port: disp_destreg_1/_2  in  PREG_W  newly renamed destination preg.
REQ-007 Port: disp_olddest_1/_2  in  PREG_W  preg previously mapped to the same areg.
REQ-008 Port: disp_pc_1/_2  in  32  instruction PC.
REQ-009 Port: disp_ready  out  1  high when at least 2 entries are free.
REQ-010 Port: disp_tag_1 / disp_tag_2  out  4  ROB index assigned to each slot; disp_tag_1 = tail, disp_tag_2 = tail+1 mod DEPTH.
REQ-011 Port: cmp_valid_1..3  in  1  completion pulse from ALU1, ALU2 and MEM respectively.
REQ-012 Port: cmp_tag_1..3  in  4  ROB index of the completing instruction.
REQ-013 Port: ret_valid_1 / ret_valid_2  out  1  instruction retires this cycle; slot 1 is older.
REQ-014 Port: ret_free_1/_2  out  1  ret_valid and ret_olddest != 0; enables the free-pool release.
REQ-015 Port: ret_olddest_1/_2, ret_destreg_1/_2  out  PREG_W  retired entry fields.
REQ-016 Port: ret_pc_1/_2  out  32  retired PC.
REQ-017 Port: count  out  5  occupied entries, 0..16.
REQ-018 Port: empty / full  out  1  count==0 / count==16.

Function
REQ-019 Storage: a circular buffer of DEPTH entries {valid, complete, destreg, olddestreg, PC}, with 4-bit head and tail pointers that wrap modulo 16.
REQ-020 Dispatch rule: a dispatch is accepted only when disp_ready=1 at the start of the cycle; disp_ready = (count <= DEPTH-2), and a retire in the same cycle does not raise it.
REQ-021 Slot rule: disp_valid_2 is ignored unless disp_valid_1=1; accepted slots write at tail and tail+1, setting valid=1 and complete=0, and tail advances by the number of accepted slots.
REQ-022 Requests while disp_ready=0 are dropped with no state change; upstream holds them.
REQ-023 Completion: cmp_valid_k=1 sets the complete bit of entry cmp_tag_k at the edge; completion to an invalid entry is ignored; multiple ports may complete distinct or identical tags in one cycle without conflict.
REQ-024 Retire is combinational from registered state: ret_valid_1 = entry[head].valid & complete, and ret_valid_2 = ret_valid_1 & entry[head+1].valid & complete; there is never out-of-order retire.
REQ-025 At the edge, retired entries are cleared (valid=0, complete=0) and head advances by the number retired (0, 1 or 2).
REQ-026 Latency: a completion pulse in cycle N produces ret_valid in cycle N+1 at the earliest; dispatch to retire is at least 2 cycles.
REQ-027 Counter: count_next = count + accepted - retired; dispatch and retire in the same cycle are both honoured.
REQ-028 Outputs: when ret_valid_k=0, ret_* data outputs are 0.
REQ-029 olddest = 0: the instruction retires normally with ret_free_k = 0.

Reset
REQ-030 reset=1 at an edge clears every entry, sets head=tail=count=0, empty=1, full=0, disp_ready=1, all ret_valid=0; this holds even mid-operation, and in-flight completions that cycle are discarded.
REQ-031 During reset, dispatch and completion inputs have no effect.

Verification
REQ-032 Scenario: dispatch A(pc 0, dest 33, old 1) and B(pc 4, dest 34, old 2), complete B, then A next cycle -> tags 0 and 1; no retire after B alone; the cycle after A completes, both retire together with ret_olddest 1 and 2.
REQ-033 Scenario: issue 8 dual dispatches with no completes -> count=16, full=1, disp_ready=0 from count 15 onward; a 9th request is dropped and tail is unchanged.
REQ-034 Scenario: fill, retire 2 per cycle while dispatching 2 per cycle across the wrap -> tags go 14, 15, 0, 1; count stays constant; retire order matches PC order.
REQ-035 Scenario: dispatch with olddest=0 then complete -> ret_valid_1=1, ret_free_1=0.
REQ-036 Scenario: assert reset with 5 entries in flight and cmp_valid_1 active -> the next cycle shows count=0, empty=1, and no retire ever appears for the flushed tags.
REQ-037 Scenario: pulse cmp_valid_1..3 together on tags 3, 3 and 9 (both valid) -> both marked complete; a completion to an invalid tag 12 leaves the state unchanged.
